// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame master: FSM state encoding,
// SPI mode constants and a small elaboration helper.
package spi_pkg;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SETUP = 3'd1;
   localparam logic [2:0] XFER  = 3'd2;
   localparam logic [2:0] HOLD  = 3'd3;
   localparam logic [2:0] GAP   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = IDLE,
      ST_SETUP = SETUP,
      ST_XFER  = XFER,
      ST_HOLD  = HOLD,
      ST_GAP   = GAP
   } spi_state_e;

   // Mode constants packed as {CPOL, CPHA}
   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: counts CLK_DIV system clocks per half-period while enabled
// and flags the leading/trailing SCLK edges in the cycle they are taken.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 200,
   parameter bit CPOL    = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en_i,
   output logic sclk_o,
   output logic lead_tick_o,
   output logic trail_tick_o
);

   localparam int HALF_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [HALF_W-1:0] halfCnt_q;
   logic              sclk_q;
   logic              wrap;

   // A tick is the cycle whose clock edge toggles sclk; lead moves away from idle
   assign wrap         = en_i && (halfCnt_q == HALF_W'(CLK_DIV - 1));
   assign lead_tick_o  = wrap && (sclk_q == CPOL);
   assign trail_tick_o = wrap && (sclk_q != CPOL);
   assign sclk_o       = sclk_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         halfCnt_q <= '0;
         sclk_q    <= CPOL;
      end else if (!en_i) begin
         halfCnt_q <= '0;
         sclk_q    <= CPOL;
      end else if (wrap) begin
         halfCnt_q <= '0;
         sclk_q    <= ~sclk_q;
      end else begin
         halfCnt_q <= halfCnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/spi_frame_master.sv
// Parametrised SPI master: one DATA_W frame per accepted start, any CPOL/CPHA,
// selectable bit order, MISO capture and a start/busy/done handshake.
module spi_frame_master
   import spi_pkg::*;
#(
   parameter int DATA_W    = 40,
   parameter int CLK_DIV   = 200,
   parameter bit CPOL      = 1'b0,
   parameter bit CPHA      = 1'b0,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CS_GAP    = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              cs_n
);

   if (DATA_W < 1 || CLK_DIV < 2 || CS_GAP < 1) begin : gBadParams
      $error("spi_frame_master: DATA_W>=1, CLK_DIV>=2 and CS_GAP>=1 are required");
   end

   localparam int EDGE_W = $clog2(2 * DATA_W + 1);
   localparam int CNT_W  = $clog2(maxInt(CLK_DIV, CS_GAP) + 1);
   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

   spi_state_e        state_q;
   logic [DATA_W-1:0] txSh_q, txSh_d;
   logic [DATA_W-1:0] rxSh_q, rxSh_d;
   logic [DATA_W-1:0] rxData_q;
   logic [EDGE_W-1:0] edge_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              csN_q, mosi_q, busy_q, done_q;
   logic              misoMeta_q, misoSync_q;
   logic              leadTick, trailTick, shiftTick, sampleTick, lastEdge, sclkEn;

   function automatic logic firstBit(input logic [DATA_W-1:0] v);
      return MSB_FIRST ? v[DATA_W-1] : v[0];
   endfunction

   // Both shift registers move toward the outgoing end, so rx ends up in transmit order
   assign txSh_d = MSB_FIRST ? (txSh_q << 1) : (txSh_q >> 1);
   assign rxSh_d = MSB_FIRST ? ((rxSh_q << 1) | DATA_W'(misoSync_q))
                             : ((rxSh_q >> 1) | (DATA_W'(misoSync_q) << (DATA_W - 1)));

   assign shiftTick  = CPHA ? leadTick  : trailTick;
   assign sampleTick = CPHA ? trailTick : leadTick;
   assign lastEdge   = (edge_q == LAST_EDGE);
   assign sclkEn     = (state_q == ST_XFER);

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV),
      .CPOL    (CPOL)
   ) uClkGen (
      .clk          (clk),
      .reset_n      (reset_n),
      .en_i         (sclkEn),
      .sclk_o       (sclk),
      .lead_tick_o  (leadTick),
      .trail_tick_o (trailTick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         misoMeta_q <= 1'b0;
         misoSync_q <= 1'b0;
      end else begin
         misoMeta_q <= miso;
         misoSync_q <= misoMeta_q;
      end
   end

   // Frame sequencer; every state transition also clears the cycle counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         txSh_q   <= '0;
         rxSh_q   <= '0;
         rxData_q <= '0;
         edge_q   <= '0;
         cnt_q    <= '0;
         csN_q    <= 1'b1;
         mosi_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  txSh_q  <= tx_data;
                  rxSh_q  <= '0;
                  csN_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  edge_q  <= '0;
                  state_q <= ST_SETUP;
                  if (!CPHA) mosi_q <= firstBit(tx_data);
               end
            end
            ST_SETUP: begin
               if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                  cnt_q   <= '0;
                  edge_q  <= '0;
                  state_q <= ST_XFER;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_XFER: begin
               if (sampleTick) rxSh_q <= rxSh_d;
               // CPHA=1 drives the current head bit; CPHA=0 already drove it at accept
               if (shiftTick && !lastEdge) begin
                  txSh_q <= txSh_d;
                  mosi_q <= CPHA ? firstBit(txSh_q) : firstBit(txSh_d);
               end
               if (leadTick || trailTick) begin
                  if (lastEdge) begin
                     edge_q  <= '0;
                     cnt_q   <= '0;
                     state_q <= ST_HOLD;
                  end else begin
                     edge_q <= edge_q + 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                  cnt_q    <= '0;
                  csN_q    <= 1'b1;
                  mosi_q   <= 1'b0;
                  rxData_q <= rxSh_q;
                  done_q   <= 1'b1;
                  state_q  <= ST_GAP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               cnt_q   <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_data = rxData_q;
   assign mosi    = mosi_q;
   assign cs_n    = csN_q;

endmodule
